aes_add_roundkey: RTL and testbench
===================================

Name: aes_add_roundkey

Overview:
- AES AddRoundKey stage: bitwise XOR of the 128-bit cipher state with the 128-bit round key.
- Used once per round in the AES encrypt/decrypt datapath, between MixColumns (or ShiftRows in the final round) and the next round.
- Parameter OUT_REG selects either a purely combinational stage or a single registered pipeline stage with a valid/ready handshake.

Parameters:
- OUT_REG, 0, 0 = combinational output; 1 = one-cycle registered output with valid/ready flow control.
- STATE_W, 128, state/key width in bits. Fixed at 128; other values are unsupported.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- input_state  input  128  AES state; bits [127:120] = byte 0 (column-major AES order).
- key  input  128  round key, same byte order as input_state.
- in_valid  input  1  input_state/key valid.
- in_ready  output  1  stage can accept input this cycle.
- output_state  output  128  input_state XOR key.
- out_valid  output  1  output_state valid.
- out_ready  input  1  downstream accepts output this cycle.

Behaviour:
- Function: output_state[i] = input_state[i] ^ key[i] for all i in 0..127. No byte reordering. Byte order is documented only for system consistency.
- OUT_REG=0:
  - output_state is driven combinationally from the current inputs; zero latency; it settles within the same cycle.
  - out_valid = in_valid; in_ready = out_ready.
  - clk and rst have no effect. No X-propagation beyond the XOR itself.
- OUT_REG=1:
  - One pipeline register stage holding the 128-bit result and a valid flag.
  - in_ready = !out_valid || out_ready. This allows full throughput of one transfer per cycle.
  - Input accept = in_valid && in_ready. On accept, output_state <= input_state ^ key and out_valid <= 1 on the next rising edge. Latency is 1 cycle.
  - Output handshake = out_valid && out_ready. If it occurs without a simultaneous accept, out_valid <= 0 and output_state holds its value.
  - Simultaneous output handshake and input accept: the register loads the new result and out_valid stays 1.
  - out_valid && !out_ready: register and out_valid hold, and in_ready = 0 (stall). The held output must not change while stalled.
  - in_valid must not be required to depend on in_ready. Inputs are sampled only on accept.
- Reset (OUT_REG=1): when rst=1 at a rising edge, out_valid <= 0 and output_state <= 0. Reset overrides any simultaneous accept, and in-flight data is dropped. in_ready = 1 during and after reset, because it follows !out_valid.
- No overflow, carry or wrap. XOR is width-preserving.

Decomposition:
- Shared package aes_pkg:
  - typedef aes_state_t (logic [127:0]);
  - typedef aes_word_t (logic [31:0]);
  - constant AES_STATE_W = 128.
- Sub-module aes_xor_word: 32-bit column XOR, instantiated 4 times (columns 0..3, bits [127:96] .. [31:0]).
- The top level holds the generate-selected output register and the handshake logic.

Test Plan:
1. OUT_REG=0, state 89c2abb23688ac1c675eb2d4cf2a263e, key 636a224c2c3d021f797f4f5e2b36011b -> output_state eaa889fe1ab5ae031e21fd8ae41c2725 after settle.
2. OUT_REG=0:
   - zero key with state 0123456789abcdef0011223344556677 -> output equals the state;
   - zero state with key fedcba9876543210ffeeddccbbaa9988 -> output equals the key;
   - all-ones state and key -> 0;
   - A5A5… XOR 5A5A… -> all FF.
3. Walking-1 through each of the 128 state bits with key DEADBEEF×4, then walking-1 through each key bit with state CAFEF00D×4 -> exactly that bit flipped relative to the other operand. Follow with 100 random vector pairs checked against a bitwise XOR.
4. OUT_REG=1 streaming: out_ready held 1, in_valid held 1, a new vector every cycle -> out_valid rises 1 cycle after the first accept; each result appears exactly 1 cycle after its input; in_ready stays 1.
5. OUT_REG=1 backpressure: out_ready=0 for 3 cycles while a result is pending -> in_ready=0, output_state and out_valid stable. When out_ready returns to 1, the pending result transfers, and a simultaneously presented input is accepted the same cycle.
6. OUT_REG=1 reset mid-operation: assert rst with out_valid=1 and in_valid=1 -> next edge gives out_valid=0, output_state=0, in_ready=1, and the pending input is not captured.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants: 128-bit state viewed as four
// 32-bit columns, column 0 in the most significant word.
package aes_pkg;

   localparam int AES_STATE_W  = 128;
   localparam int AES_WORD_W   = 32;
   localparam int AES_NUM_COLS = AES_STATE_W / AES_WORD_W;

   typedef logic [AES_STATE_W-1:0] aes_state_t;
   typedef logic [AES_WORD_W-1:0]  aes_word_t;

   // Column c occupies bits [127-32c -: 32] (column-major byte order).
   function automatic aes_word_t get_column(input aes_state_t s, input int c);
      return s[AES_STATE_W-1-c*AES_WORD_W -: AES_WORD_W];
   endfunction

endpackage

// File: rtl/aes_xor_word.sv
// One AES state column (32 bits) XORed with the matching round-key column.
module aes_xor_word
   import aes_pkg::*;
(
   input  logic [AES_WORD_W-1:0] state_word,
   input  logic [AES_WORD_W-1:0] key_word,
   output logic [AES_WORD_W-1:0] result_word
);

   assign result_word = state_word ^ key_word;

endmodule

// File: rtl/aes_add_roundkey.sv
// AES AddRoundKey: state XOR round key, either purely combinational
// (OUT_REG=0) or behind a single valid/ready pipeline register (OUT_REG=1).
module aes_add_roundkey
   import aes_pkg::*;
#(
   parameter int OUT_REG = 0,
   parameter int STATE_W = AES_STATE_W
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [STATE_W-1:0] input_state,
   input  logic [STATE_W-1:0] key,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [STATE_W-1:0] output_state,
   output logic               out_valid,
   input  logic               out_ready
);

   // Handshake: a transfer happens on a rising edge where valid && ready.
   // valid never waits on ready; once raised, valid and data hold until
   // the transfer; ready may depend on valid of the downstream side only.
   aes_state_t xor_result;

   for (genvar c = 0; c < AES_NUM_COLS; c++) begin : g_col
      aes_xor_word u_xor_word (
         .state_word  (get_column(input_state, c)),
         .key_word    (get_column(key, c)),
         .result_word (xor_result[AES_STATE_W-1-c*AES_WORD_W -: AES_WORD_W])
      );
   end

   if (OUT_REG == 0) begin : g_comb
      // Clock and reset are intentionally unused in the combinational build.
      logic unused_sync;
      assign unused_sync  = clk ^ rst;

      assign output_state = xor_result;
      assign out_valid    = in_valid;
      assign in_ready     = out_ready;
   end else begin : g_reg
      logic       valid_q;
      aes_state_t data_q;
      logic       accept;

      // Register is free when empty or when its content leaves this cycle.
      assign in_ready = !valid_q || out_ready;
      assign accept   = in_valid && in_ready;

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else if (accept) begin
            data_q  <= xor_result;
            valid_q <= 1'b1;
         end else if (out_ready) begin
            valid_q <= 1'b0;
         end
      end

      assign output_state = data_q;
      assign out_valid    = valid_q;
   end

endmodule

// File: tb/tb_aes_add_roundkey.sv
// Bench for aes_add_roundkey: one combinational and one registered instance,
// each with a stimulus driver, an expected queue and a decoupled monitor.
module tb_aes_add_roundkey;
   import aes_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // combinational instance
   logic [127:0] c_state, c_key, c_out;
   logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready;
   // registered instance
   logic [127:0] r_state, r_key, r_out;
   logic         r_in_valid, r_in_ready, r_out_valid, r_out_ready;

   aes_add_roundkey #(.OUT_REG(0), .STATE_W(128)) u_comb (
      .clk(clk), .rst(rst), .input_state(c_state), .key(c_key),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .output_state(c_out),
      .out_valid(c_out_valid), .out_ready(c_out_ready));

   aes_add_roundkey #(.OUT_REG(1), .STATE_W(128)) u_reg (
      .clk(clk), .rst(rst), .input_state(r_state), .key(r_key),
      .in_valid(r_in_valid), .in_ready(r_in_ready), .output_state(r_out),
      .out_valid(r_out_valid), .out_ready(r_out_ready));

   logic [127:0] c_exp_q[$];
   logic [127:0] r_exp_q[$];
   int           r_acc_q[$];
   bit           c_mon_en = 0;
   bit           r_mon_en = 0;
   bit           rand_rdy = 0;

   // Reference: every result bit is the XOR of the same-position operand bits.
   function automatic logic [127:0] ref_ark(input logic [127:0] s, input logic [127:0] k);
      logic [127:0] r;
      for (int i = 0; i < 128; i++) r[i] = (s[i] != k[i]);
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- combinational monitor ----------------
   always @(negedge clk) begin
      if (c_mon_en) begin
         chk("comb_in_ready", {127'd0, c_in_ready}, {127'd0, c_out_ready});
         chk("comb_out_valid", {127'd0, c_out_valid}, {127'd0, c_in_valid});
         if (c_out_valid === 1'b1) begin
            if (c_exp_q.size() == 0) chk("comb_unexpected", 128'd1, 128'd0);
            else chk("comb_data", c_out, c_exp_q.pop_front());
         end
      end
   end

   // ---------------- registered monitor ----------------
   bit           prev_stall = 0;
   logic [127:0] held;
   always @(negedge clk) begin
      if (r_mon_en && !rst) begin
         chk("reg_in_ready_rule", {127'd0, r_in_ready}, {127'd0, (!r_out_valid || r_out_ready)});
         if (prev_stall) begin
            chk("reg_stall_valid", {127'd0, r_out_valid}, 128'd1);
            chk("reg_stall_hold", r_out, held);
         end else if (r_out_valid === 1'b1) begin
            if (r_acc_q.size() == 0) chk("reg_unexpected", 128'd1, 128'd0);
            else chk("reg_latency", cyc, r_acc_q[0] + 1);
         end
         if (r_out_valid === 1'b1 && r_out_ready === 1'b1) begin
            if (r_exp_q.size() == 0) chk("reg_unexpected_xfer", 128'd1, 128'd0);
            else begin
               chk("reg_data", r_out, r_exp_q.pop_front());
               void'(r_acc_q.pop_front());
            end
         end
         prev_stall = (r_out_valid === 1'b1) && (r_out_ready !== 1'b1);
         held       = r_out;
      end else begin
         prev_stall = 0;
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1;
         r_out_ready = 1'($urandom_range(0, 1));
      end
   end

   // ---------------- driver tasks (called at posedge+1) ----------------
   task automatic comb_apply(input logic [127:0] s, input logic [127:0] k,
                             input logic [127:0] exp, input bit v);
      c_state     = s;
      c_key       = k;
      c_in_valid  = v;
      c_out_ready = 1'($urandom_range(0, 1));
      if (v) c_exp_q.push_back(exp);
      @(posedge clk); #1;
   endtask

   task automatic reg_send(input logic [127:0] s, input logic [127:0] k, output int waits);
      waits      = 0;
      r_state    = s;
      r_key      = k;
      r_in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (r_in_ready === 1'b1) begin
            r_exp_q.push_back(ref_ark(s, k));
            r_acc_q.push_back(cyc);
            break;
         end
         waits++;
         if (waits > 50) begin
            chk("reg_send_timeout", 128'd1, 128'd0);
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      r_in_valid = 1'b0;
   endtask

   task automatic reg_drain();
      int n = 0;
      while (r_exp_q.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reg_drain_empty", 128'(r_exp_q.size()), 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] s, k, e, a_exp;
      int           w;
      c_state = '0; c_key = '0; c_in_valid = 0; c_out_ready = 0;
      r_state = '0; r_key = '0; r_in_valid = 0; r_out_ready = 0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", {127'd0, r_out_valid}, 128'd0);
      chk("reset_out_state", r_out, 128'd0);
      chk("reset_in_ready", {127'd0, r_in_ready}, 128'd1);
      @(posedge clk); #1;
      c_mon_en = 1;
      r_mon_en = 1;

      // directed combinational vectors with hand-derived results
      comb_apply(128'h89c2abb23688ac1c675eb2d4cf2a263e, 128'h636a224c2c3d021f797f4f5e2b36011b,
                 128'heaa889fe1ab5ae031e21fd8ae41c2725, 1);
      comb_apply(128'h0123456789abcdef0011223344556677, 128'h0,
                 128'h0123456789abcdef0011223344556677, 1);
      comb_apply(128'h0, 128'hfedcba9876543210ffeeddccbbaa9988,
                 128'hfedcba9876543210ffeeddccbbaa9988, 1);
      comb_apply({128{1'b1}}, {128{1'b1}}, 128'h0, 1);
      comb_apply({16{8'ha5}}, {16{8'h5a}}, {128{1'b1}}, 1);

      // walking one through the state, then through the key
      k = {4{32'hdeadbeef}};
      for (int i = 0; i < 128; i++) begin
         s = '0; s[i] = 1'b1;
         e = k;  e[i] = ~e[i];
         comb_apply(s, k, e, 1);
      end
      s = {4{32'hcafef00d}};
      for (int i = 0; i < 128; i++) begin
         k = '0; k[i] = 1'b1;
         e = s;  e[i] = ~e[i];
         comb_apply(s, k, e, 1);
      end
      for (int i = 0; i < 100; i++) begin
         s = rand128();
         k = rand128();
         comb_apply(s, k, ref_ark(s, k), 1'($urandom_range(0, 3) != 0));
      end
      c_in_valid = 0;
      @(posedge clk); #1;
      chk("comb_queue_empty", 128'(c_exp_q.size()), 128'd0);

      // registered: full-rate streaming
      r_out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         reg_send(rand128(), rand128(), w);
         chk("stream_no_wait", 128'(w), 128'd0);
      end
      reg_drain();

      // registered: backpressure with a pending result
      r_out_ready = 1'b0;
      s = rand128();
      k = rand128();
      a_exp = ref_ark(s, k);
      reg_send(s, k, w);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {127'd0, r_in_ready}, 128'd0);
         chk("bp_out_valid", {127'd0, r_out_valid}, 128'd1);
         chk("bp_out_state", r_out, a_exp);
         @(posedge clk); #1;
      end
      r_out_ready = 1'b1;
      reg_send(rand128(), rand128(), w);
      chk("bp_same_cycle_accept", 128'(w), 128'd0);
      reg_drain();

      // registered: random backpressure and gaps
      rand_rdy = 1;
      for (int i = 0; i < 100; i++) begin
         reg_send(rand128(), rand128(), w);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      rand_rdy = 0;
      @(posedge clk); #1;
      r_out_ready = 1'b1;
      reg_drain();

      // registered: reset with a pending result and a presented input
      r_out_ready = 1'b0;
      reg_send(rand128(), rand128(), w);
      rst         = 1'b1;
      r_state     = rand128();
      r_key       = rand128();
      r_in_valid  = 1'b1;
      r_out_ready = 1'b1;
      @(posedge clk); #1;
      rst        = 1'b0;
      r_in_valid = 1'b0;
      r_exp_q.delete();
      r_acc_q.delete();
      @(negedge clk);
      chk("rst_mid_out_valid", {127'd0, r_out_valid}, 128'd0);
      chk("rst_mid_out_state", r_out, 128'd0);
      chk("rst_mid_in_ready", {127'd0, r_in_ready}, 128'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_not_captured", {127'd0, r_out_valid}, 128'd0);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
